// File: rtl/moonbase_extbus_arbiter.sv
// moonbase_extbus_arbiter
// Two-port arbiter and sequencer for the moonbase external nibble bus.
// One granted requester at a time gets a full byte transaction:
// an address latch strobe, then the high nibble, then the low nibble.
// Read data comes back with a one-cycle ack.
// Optional feature macro: MOONBASE_ARB_RR_EN
//   defined   -> round-robin arbitration between the two ports
//   undefined -> fixed priority, port 0 (CPU) wins ties
module moonbase_extbus_arbiter #(
    parameter logic [7:0] IDLE_BUS = 8'h70
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ram_in,
    input  logic [1:0] dev_in,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic       tgt0,
    input  logic       tgt1,
    input  logic       code0,
    input  logic       code1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [1:0] rdev,
    output logic       gnt,
    output logic       busy,
    output logic [7:0] bus_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_HI,
        S_LO
    } state_t;

    state_t     state_q, state_d;
    logic       we_q, we_d;
    logic       tgt_q, tgt_d;
    logic       code_q, code_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       gnt_q, gnt_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] rdev_q, rdev_d;

    logic       act0, act1;
    logic       winner;
    logic       ramWeN, devWeN;
    logic [3:0] nibble;

    // A port that is being acked this cycle sits out this arbitration round
    assign act0 = req0 & ~ack0_q;
    assign act1 = req1 & ~ack1_q;

`ifdef MOONBASE_ARB_RR_EN
    logic ptr_q;

    // Round-robin tie break: the pointer names the favoured port
    always_comb begin
        winner = act1;
        if (act0 && act1) begin
            winner = ptr_q;
        end
    end

    // After each grant, favour the port that did not win
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (state_q == S_IDLE && (act0 || act1)) begin
            ptr_q <= ~winner;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not active
    always_comb begin
        winner = ~act0;
    end
`endif

    // Next-state, transaction latch, read capture and ack generation
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        tgt_d   = tgt_q;
        code_d  = code_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        rdev_d  = rdev_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act0 || act1) begin
                    state_d = S_ADDR;
                    gnt_d   = winner;
                    if (winner) begin
                        we_d    = we1;
                        tgt_d   = tgt1;
                        code_d  = code1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                    end else begin
                        we_d    = we0;
                        tgt_d   = tgt0;
                        code_d  = code0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_HI;
            end
            S_HI: begin
                state_d = S_LO;
                if (!we_q) begin
                    rdata_d[7:4] = ram_in;
                end
            end
            S_LO: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    rdata_d[3:0] = ram_in;
                    rdev_d       = dev_in;
                end
                ack0_d = ~gnt_q;
                ack1_d = gnt_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            tgt_q   <= 1'b0;
            code_q  <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 8'd0;
            gnt_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= 8'd0;
            rdev_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            tgt_q   <= tgt_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rdata_q <= rdata_d;
            rdev_q  <= rdev_d;
        end
    end

    assign ramWeN = ~(we_q & ~tgt_q);
    assign devWeN = ~(we_q & tgt_q);
    assign nibble = (state_q == S_HI) ? wdata_q[7:4] : wdata_q[3:0];

    // External bus mux; write strobes only ever appear in the nibble phases
    always_comb begin
        bus_out = IDLE_BUS;
        case (state_q)
            S_ADDR:     bus_out = {1'b1, addr_q};
            S_HI, S_LO: bus_out = {1'b0, code_q, ramWeN, devWeN, nibble};
            default:    bus_out = IDLE_BUS;
        endcase
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign rdata = rdata_q;
    assign rdev  = rdev_q;
    assign gnt   = gnt_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_moonbase_extbus_arbiter.sv
// tb_moonbase_extbus_arbiter
// Self-checking bench for moonbase_extbus_arbiter. Expected bus bytes and
// read results are queued when a request is driven and popped as the DUT
// walks through ADDR/HI/LO/ack. Build with or without MOONBASE_ARB_RR_EN.
module tb_moonbase_extbus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ram_in;
    logic [1:0] dev_in;
    logic       req0, req1, we0, we1, tgt0, tgt1, code0, code1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, gnt, busy;
    logic [7:0] rdata, bus_out;
    logic [1:0] rdev;

    int total = 0;
    int bad   = 0;

    logic [7:0] expBus[$];
    logic       expGnt[$];
    logic [7:0] lastRd;
    logic [1:0] lastRdev;
    logic       ptrModel;

    moonbase_extbus_arbiter dut (
        .clk(clk), .reset(reset), .ram_in(ram_in), .dev_in(dev_in),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .tgt0(tgt0), .tgt1(tgt1), .code0(code0), .code1(code1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .rdev(rdev),
        .gnt(gnt), .busy(busy), .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    // Absolute run-time guard
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic drivePort(input bit port, input bit we, input bit tgt, input bit code,
                             input logic [6:0] addr, input logic [7:0] wdata);
        if (port) begin
            we1 = we; tgt1 = tgt; code1 = code; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end else begin
            we0 = we; tgt0 = tgt; code0 = code; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end
    endtask

    task automatic waitBusy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One single-port transaction with literal expected bus bytes
    task automatic doTxn(input string name, input bit port, input bit we, input bit tgt,
                         input bit code, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [3:0] hi, input logic [3:0] lo, input logic [1:0] dv,
                         input logic [7:0] eAddr, input logic [7:0] eHi, input logic [7:0] eLo);
        bit ok;
        logic [7:0] e;
        logic [7:0] expRd;
        logic ackMine, ackOther;
        expBus.push_back(eAddr);
        expBus.push_back(eHi);
        expBus.push_back(eLo);
        expRd = we ? lastRd : {hi, lo};
        @(negedge clk);
        drivePort(port, we, tgt, code, addr, wdata);
        waitBusy(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s grant: got busy=%b expected 1", name, busy);
            expBus.delete();
            req0 = 1'b0; req1 = 1'b0;
            return;
        end
        total++;
        if (gnt !== port) begin
            bad++; $display("[TB] FAIL %s gnt: got %b expected %b", name, gnt, port);
        end
        e = expBus.pop_front();
        total++;
        if (bus_out !== e) begin
            bad++; $display("[TB] FAIL %s addr phase: got %h expected %h", name, bus_out, e);
        end
        ram_in = hi;
        @(negedge clk);
        e = expBus.pop_front();
        total++;
        if (bus_out !== e) begin
            bad++; $display("[TB] FAIL %s hi phase: got %h expected %h", name, bus_out, e);
        end
        @(negedge clk);
        e = expBus.pop_front();
        total++;
        if (bus_out !== e) begin
            bad++; $display("[TB] FAIL %s lo phase: got %h expected %h", name, bus_out, e);
        end
        ram_in = lo;
        dev_in = dv;
        @(negedge clk);
        ackMine  = port ? ack1 : ack0;
        ackOther = port ? ack0 : ack1;
        total++;
        if (ackMine !== 1'b1 || ackOther !== 1'b0) begin
            bad++; $display("[TB] FAIL %s ack: got mine=%b other=%b expected 1 0", name, ackMine, ackOther);
        end
        total++;
        if (rdata !== expRd) begin
            bad++; $display("[TB] FAIL %s rdata: got %h expected %h", name, rdata, expRd);
        end
        if (!we) begin
            total++;
            if (rdev !== dv) begin
                bad++; $display("[TB] FAIL %s rdev: got %h expected %h", name, rdev, dv);
            end
            lastRdev = dv;
        end
        total++;
        if (bus_out !== 8'h70 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL %s ack-cycle idle: got bus=%h busy=%b expected 70 0", name, bus_out, busy);
        end
        req0 = 1'b0; req1 = 1'b0;
        lastRd   = expRd;
        ptrModel = ~port;
        @(negedge clk);
        total++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL %s after ack: got ack0=%b ack1=%b busy=%b expected 0 0 0", name, ack0, ack1, busy);
        end
        ram_in = 4'h0;
        dev_in = 2'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; tgt0 = 0; tgt1 = 0; code0 = 0; code1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; ram_in = 0; dev_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lastRd = 8'h00; lastRdev = 2'h0; ptrModel = 1'b0;
        total++;
        if (bus_out !== 8'h70) begin
            bad++; $display("[TB] FAIL reset bus: got %h expected 70", bus_out);
        end
        total++;
        if ({ack0, ack1, busy, gnt} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset ctl: got %b expected 0000", {ack0, ack1, busy, gnt});
        end
        total++;
        if (rdata !== 8'h00 || rdev !== 2'h0) begin
            bad++; $display("[TB] FAIL reset data: got %h/%h expected 00/0", rdata, rdev);
        end
    endtask

    task automatic test_sram_write();
        doTxn("sram_wr", 1'b0, 1'b1, 1'b0, 1'b0, 7'h15, 8'hA5, 4'h0, 4'h0, 2'h0,
              8'h95, 8'h1A, 8'h15);
    endtask

    task automatic test_sram_read();
        doTxn("sram_rd", 1'b1, 1'b0, 1'b0, 1'b1, 7'h03, 8'h00, 4'h6, 4'h9, 2'h2,
              8'h83, 8'h70, 8'h70);
    endtask

    task automatic test_dev_write();
        doTxn("dev_wr", 1'b0, 1'b1, 1'b1, 1'b0, 7'h2B, 8'h3C, 4'hF, 4'hF, 2'h3,
              8'hAB, 8'h23, 8'h2C);
    endtask

    task automatic test_dev_read();
        doTxn("dev_rd", 1'b0, 1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 4'hA, 4'h5, 2'h1,
              8'hFF, 8'h30, 8'h30);
    endtask

    // Both ports held: first pick is the tie-break, then the ack mask alternates
    task automatic test_back_to_back();
        bit ok;
        logic first, e;
        logic ackE, ackN;
`ifdef MOONBASE_ARB_RR_EN
        first = ptrModel;
`else
        first = 1'b0;
`endif
        expGnt.push_back(first);
        expGnt.push_back(~first);
        expGnt.push_back(first);
        expGnt.push_back(~first);
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b0, 1'b0, 7'h11, 8'h5A);
        drivePort(1'b1, 1'b1, 1'b0, 1'b0, 7'h22, 8'hC3);
        waitBusy(ok);
        total++;
        if (!ok) begin
            bad++; $display("[TB] FAIL b2b grant: got busy=%b expected 1", busy);
            expGnt.delete();
            req0 = 1'b0; req1 = 1'b0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            e = expGnt.pop_front();
            if (k > 0) @(negedge clk);
            total++;
            if (busy !== 1'b1 || gnt !== e) begin
                bad++; $display("[TB] FAIL b2b gnt%0d: got busy=%b gnt=%b expected 1 %b", k, busy, gnt, e);
            end
            total++;
            if (bus_out !== (e ? 8'hA2 : 8'h91)) begin
                bad++; $display("[TB] FAIL b2b addr%0d: got %h expected %h", k, bus_out, e ? 8'hA2 : 8'h91);
            end
            repeat (3) @(negedge clk);
            ackE = e ? ack1 : ack0;
            ackN = e ? ack0 : ack1;
            total++;
            if (ackE !== 1'b1 || ackN !== 1'b0) begin
                bad++; $display("[TB] FAIL b2b ack%0d: got %b %b expected 1 0", k, ackE, ackN);
            end
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        ptrModel = first;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b drain: got busy=%b expected 0", busy);
        end
    endtask

    // Port 0 held through its ack: no regrant in the ack cycle, regrant one cycle later
    task automatic test_ack_mask();
        bit ok;
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b0, 1'b1, 7'h05, 8'h12);
        waitBusy(ok);
        total++;
        if (!ok) begin
            bad++; $display("[TB] FAIL mask grant: got busy=%b expected 1", busy);
            req0 = 1'b0;
            return;
        end
        repeat (3) @(negedge clk);
        total++;
        if (ack0 !== 1'b1) begin
            bad++; $display("[TB] FAIL mask ack: got %b expected 1", ack0);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL mask no-regrant: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || gnt !== 1'b0) begin
            bad++; $display("[TB] FAIL mask regrant: got busy=%b gnt=%b expected 1 0", busy, gnt);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ack0 !== 1'b1) begin
            bad++; $display("[TB] FAIL mask ack2: got %b expected 1", ack0);
        end
        req0 = 1'b0;
        ptrModel = 1'b1;
        @(negedge clk);
    endtask

    // Reset during HI of a write aborts cleanly; a following request completes
    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b0, 1'b0, 7'h40, 8'hF0);
        waitBusy(ok);
        total++;
        if (!ok) begin
            bad++; $display("[TB] FAIL rstmid grant: got busy=%b expected 1", busy);
            req0 = 1'b0;
            return;
        end
        @(negedge clk);
        total++;
        if (bus_out !== 8'h1F) begin
            bad++; $display("[TB] FAIL rstmid hi: got %h expected 1F", bus_out);
        end
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        total++;
        if (bus_out !== 8'h70 || busy !== 1'b0 || ack0 !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid abort: got bus=%h busy=%b ack0=%b expected 70 0 0", bus_out, busy, ack0);
        end
        reset = 1'b0;
        lastRd = 8'h00; lastRdev = 2'h0; ptrModel = 1'b0;
        @(negedge clk);
        total++;
        if (ack0 !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid no-ack: got ack0=%b busy=%b expected 0 0", ack0, busy);
        end
        doTxn("post_rst_wr", 1'b0, 1'b1, 1'b0, 1'b1, 7'h01, 8'h96, 4'h0, 4'h0, 2'h0,
              8'h81, 8'h59, 8'h56);
        doTxn("post_rst_rd", 1'b1, 1'b0, 1'b0, 1'b0, 7'h7E, 8'h00, 4'hC, 4'h3, 2'h2,
              8'hFE, 8'h30, 8'h30);
    endtask

    initial begin
        test_reset();
        test_sram_write();
        test_sram_read();
        test_dev_write();
        test_dev_read();
        test_back_to_back();
        test_ack_mask();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
